// File: rtl/idecode_if.sv
// Fetch -> decode handshake.
// Fetch (master) presents an instruction, its PC and a valid flag. Decode
// (slave) answers with fetch_stall when it cannot accept the instruction.
//   instr_valid  fetch presents an instruction
//   instruction  32-bit instruction word
//   pc_current   PC of the presented instruction
//   fetch_stall  decode cannot accept this cycle
interface idecode_if #(
    parameter int XLEN = 64
);
    logic            instr_valid;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc_current;
    logic            fetch_stall;

    modport master (
        output instr_valid, instruction, pc_current,
        input  fetch_stall
    );

    modport slave (
        input  instr_valid, instruction, pc_current,
        output fetch_stall
    );
endinterface

// File: rtl/idecode.sv
// RV64I instruction decode stage.
// Decodes one instruction per fetch transfer into a single-entry output
// register for execute. The entry is held while execute stalls, and fetch is
// stalled when the entry is occupied and cannot drain.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   fetch         fetch handshake (instr_valid/instruction/pc_current in,
//                 fetch_stall out)
//   ex_stall      execute cannot accept the held instruction
//   flush         drop the held and the incoming instruction
//   id_*          decoded instruction held for execute
module idecode #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    idecode_if.slave        fetch,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] id_imm,
    output logic [3:0]      id_alu_op,
    output logic [2:0]      id_funct3,
    output logic            id_alu_src_imm,
    output logic            id_alu_src_pc,
    output logic            id_is_word,
    output logic            id_reg_write,
    output logic            id_mem_read,
    output logic            id_mem_write,
    output logic            id_branch,
    output logic            id_jal,
    output logic            id_jalr,
    output logic            id_rs1_used,
    output logic            id_rs2_used,
    output logic            id_illegal
);
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        alu_op_e         alu_op;
        logic [2:0]      funct3;
        logic            alu_src_imm;
        logic            alu_src_pc;
        logic            is_word;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            rs1_used;
        logic            rs2_used;
        logic            illegal;
    } decoded_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Integer ALU operation selected by funct3; alt selects SUB/SRA.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;
    logic            is_shift;
    logic            word_f3_ok;
    decoded_t        dec;
    decoded_t        held;
    logic            in_ready;
    logic            capture;

    assign instr  = fetch.instruction;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i     = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s     = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b     = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
    assign imm_j     = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_shamt = {{(XLEN-6){1'b0}}, instr[25:20]};

    assign is_shift   = (f3 == 3'b001) || (f3 == 3'b101);
    assign word_f3_ok = (f3 == 3'b000) || is_shift;

    always_comb begin
        // NOTE: every field gets a default first so no path through the case
        // leaves one unassigned, which would infer a latch.
        dec        = '0;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];
        dec.funct3 = f3;
        dec.alu_op = ALU_ADD;

        case (opcode)
            OPC_LUI: begin
                dec.imm         = imm_u;
                dec.alu_op      = ALU_PASSB;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm         = imm_u;
                dec.alu_src_imm = 1'b1;
                dec.alu_src_pc  = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_JAL: begin
                // ALU forms the target pc+imm; the link value comes from execute.
                dec.imm         = imm_j;
                dec.alu_src_imm = 1'b1;
                dec.alu_src_pc  = 1'b1;
                dec.jal         = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_JALR: begin
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.jalr        = 1'b1;
                dec.reg_write   = 1'b1;
                dec.rs1_used    = 1'b1;
                dec.illegal     = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.imm      = imm_b;
                dec.branch   = 1'b1;
                dec.rs1_used = 1'b1;
                dec.rs2_used = 1'b1;
                dec.illegal  = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.mem_read    = 1'b1;
                dec.reg_write   = 1'b1;
                dec.rs1_used    = 1'b1;
                dec.illegal     = (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec.imm         = imm_s;
                dec.alu_src_imm = 1'b1;
                dec.mem_write   = 1'b1;
                dec.rs1_used    = 1'b1;
                dec.rs2_used    = 1'b1;
                dec.illegal     = f3[2];
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                dec.imm         = is_shift ? imm_shamt : imm_i;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                dec.rs1_used    = 1'b1;
                // Bit 30 only means "arithmetic" for right shifts; for ADDI it is immediate.
                dec.alu_op      = alu_from_funct3(f3, (f3 == 3'b101) && instr[30]);
                if (f3 == 3'b001)
                    dec.illegal = (instr[31:26] != 6'b000000);
                else if (f3 == 3'b101)
                    dec.illegal = (instr[31:26] != 6'b000000) && (instr[31:26] != 6'b010000);
                if (opcode == OPC_OP_IMM32) begin
                    dec.is_word = 1'b1;
                    if (!word_f3_ok || (is_shift && instr[25]))
                        dec.illegal = 1'b1;
                end
            end
            OPC_OP, OPC_OP32: begin
                dec.reg_write = 1'b1;
                dec.rs1_used  = 1'b1;
                dec.rs2_used  = 1'b1;
                dec.alu_op    = alu_from_funct3(f3, instr[30]);
                if (f7 == 7'b0100000)
                    dec.illegal = (f3 != 3'b000) && (f3 != 3'b101);
                else
                    dec.illegal = (f7 != 7'b0000000);
                if (opcode == OPC_OP32) begin
                    dec.is_word = 1'b1;
                    if (!word_f3_ok)
                        dec.illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // FENCE is a NOP in this in-order pipeline.
            end
            OPC_SYSTEM: begin
                dec.illegal = (instr != 32'h0000_0073) && (instr != 32'h0010_0073);
            end
            default: begin
                // Unlisted opcodes, including any word with bits[1:0] != 11.
                dec.illegal = 1'b1;
            end
        endcase

        if (dec.illegal) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jal       = 1'b0;
            dec.jalr      = 1'b0;
        end
    end

    assign in_ready          = !id_valid || !ex_stall;
    assign fetch.fetch_stall = !in_ready;
    assign capture           = fetch.instr_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!resetn) begin
            // NOTE: the data fields are reset too, because every output must
            // read 0 after reset, not only id_valid.
            id_valid <= 1'b0;
            id_pc    <= '0;
            held     <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (capture) begin
            id_valid <= 1'b1;
            id_pc    <= fetch.pc_current;
            held     <= dec;
        end else if (!ex_stall) begin
            id_valid <= 1'b0;
        end
    end

    assign id_rs1         = held.rs1;
    assign id_rs2         = held.rs2;
    assign id_rd          = held.rd;
    assign id_imm         = held.imm;
    assign id_alu_op      = held.alu_op;
    assign id_funct3      = held.funct3;
    assign id_alu_src_imm = held.alu_src_imm;
    assign id_alu_src_pc  = held.alu_src_pc;
    assign id_is_word     = held.is_word;
    assign id_reg_write   = held.reg_write;
    assign id_mem_read    = held.mem_read;
    assign id_mem_write   = held.mem_write;
    assign id_branch      = held.branch;
    assign id_jal         = held.jal;
    assign id_jalr        = held.jalr;
    assign id_rs1_used    = held.rs1_used;
    assign id_rs2_used    = held.rs2_used;
    assign id_illegal     = held.illegal;
endmodule

// File: tb/tb_idecode.sv
// Directed testbench for idecode: hand-computed vectors, one task per scenario.
module tb_idecode;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic [63:0] id_pc, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_alu_src_imm, id_alu_src_pc, id_is_word;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jal, id_jalr;
    logic        id_rs1_used, id_rs2_used, id_illegal;
    logic [5:0]  flags;

    int vectors = 0;
    int miscompares = 0;

    idecode_if #(.XLEN(64)) fif ();

    idecode #(.XLEN(64)) dut (
        .clk(clk), .resetn(resetn), .fetch(fif.slave),
        .ex_stall(ex_stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_imm(id_imm), .id_alu_op(id_alu_op), .id_funct3(id_funct3),
        .id_alu_src_imm(id_alu_src_imm), .id_alu_src_pc(id_alu_src_pc),
        .id_is_word(id_is_word),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_jal(id_jal), .id_jalr(id_jalr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_illegal(id_illegal)
    );

    // {reg_write, mem_read, mem_write, branch, jal, jalr}
    assign flags = {id_reg_write, id_mem_read, id_mem_write, id_branch, id_jal, id_jalr};

    always #5 clk = ~clk;

    // Drive fetch-side inputs on the falling edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic stall, input logic fl);
        @(negedge clk);
        fif.instr_valid = v;
        fif.instruction = ins;
        fif.pc_current  = pc;
        ex_stall        = stall;
        flush           = fl;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        fif.instr_valid = 1'b0;
        fif.instruction = 32'h0;
        fif.pc_current  = 64'h0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({id_valid, fif.fetch_stall, flags, id_illegal} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got valid=%b stall=%b flags=%b ill=%b exp all 0",
                     id_valid, fif.fetch_stall, flags, id_illegal);
        end
        vectors++;
        if ({id_pc, id_imm, id_rd, id_rs1, id_rs2, id_alu_op} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got pc=%h imm=%h rd=%0d alu=%0d exp 0",
                     id_pc, id_imm, id_rd, id_alu_op);
        end
        @(negedge clk);
        resetn = 1'b1;
        settle();
        vectors++;
        if (id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_valid: got %b exp 0", id_valid);
        end
    endtask

    task automatic test_addi();
        drive(1'b1, 32'h0050_0093, 64'h1000, 1'b0, 1'b0);
        settle();
        vectors++;
        if ({id_valid, id_rd, id_rs1, id_alu_op, id_alu_src_imm, id_illegal} !== {1'b1, 5'd1, 5'd0, 4'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL addi_fields: got v=%b rd=%0d rs1=%0d alu=%0d simm=%b ill=%b exp 1/1/0/0/1/0",
                     id_valid, id_rd, id_rs1, id_alu_op, id_alu_src_imm, id_illegal);
        end
        vectors++;
        if ({id_imm, id_pc, flags} !== {64'd5, 64'h1000, 6'b100000}) begin
            miscompares++;
            $display("FAIL addi_imm_pc: got imm=%h pc=%h flags=%b exp 5/1000/100000",
                     id_imm, id_pc, flags);
        end
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        settle();
        vectors++;
        if (id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL addi_drain: got valid=%b exp 0", id_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h4020_81B3, 64'h2000, 1'b0, 1'b0);
        settle();
        vectors++;
        if ({id_valid, id_alu_op, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used, flags}
            !== {1'b1, 4'd1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 6'b100000}) begin
            miscompares++;
            $display("FAIL sub: got v=%b alu=%0d rs1=%0d rs2=%0d rd=%0d used=%b%b flags=%b",
                     id_valid, id_alu_op, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used, flags);
        end
        drive(1'b1, 32'hFE20_8EE3, 64'h2004, 1'b0, 1'b0);
        settle();
        vectors++;
        if ({id_valid, id_imm, flags, id_rs1, id_rs2, id_pc} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 6'b000100, 5'd1, 5'd2, 64'h2004}) begin
            miscompares++;
            $display("FAIL beq: got v=%b imm=%h flags=%b rs1=%0d rs2=%0d pc=%h",
                     id_valid, id_imm, flags, id_rs1, id_rs2, id_pc);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'hFF81_2283, 64'h3000, 1'b0, 1'b0);
        settle();
        // Second instruction (addi x1,x0,5) waits behind a 3-cycle execute stall.
        drive(1'b1, 32'h0050_0093, 64'h3004, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            vectors++;
            if ({id_valid, fif.fetch_stall, id_rd, id_rs1, id_imm, flags, id_pc}
                !== {1'b1, 1'b1, 5'd5, 5'd2, 64'hFFFF_FFFF_FFFF_FFF8, 6'b110000, 64'h3000}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got v=%b fs=%b rd=%0d rs1=%0d imm=%h flags=%b pc=%h",
                         i, id_valid, fif.fetch_stall, id_rd, id_rs1, id_imm, flags, id_pc);
            end
        end
        @(negedge clk);
        ex_stall = 1'b0;
        #1;
        vectors++;
        if ({fif.fetch_stall, id_rd} !== {1'b0, 5'd5}) begin
            miscompares++;
            $display("FAIL stall_release: got fs=%b rd=%0d exp 0/5", fif.fetch_stall, id_rd);
        end
        settle();
        vectors++;
        if ({id_valid, id_rd, id_imm, id_pc} !== {1'b1, 5'd1, 64'd5, 64'h3004}) begin
            miscompares++;
            $display("FAIL stall_second: got v=%b rd=%0d imm=%h pc=%h exp 1/1/5/3004",
                     id_valid, id_rd, id_imm, id_pc);
        end
    endtask

    task automatic test_flush();
        // id_valid=1 holding addi (rd=1); flush beats both hold and capture.
        drive(1'b1, 32'h4020_81B3, 64'h4000, 1'b1, 1'b1);
        settle();
        vectors++;
        if ({id_valid, fif.fetch_stall, id_rd} !== {1'b0, 1'b0, 5'd1}) begin
            miscompares++;
            $display("FAIL flush: got v=%b fs=%b rd=%0d exp 0/0/1", id_valid, fif.fetch_stall, id_rd);
        end
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        settle();
        vectors++;
        if (id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_after: got v=%b exp 0", id_valid);
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [3:0]  alu;
        logic [5:0]  fl;
        logic        simm, spc, word;
    } vec_t;

    task automatic test_opcodes();
        vec_t t[11];
        t[0]  = '{32'h1234_5037, 5'd0, 64'h0000_0000_1234_5000, 4'd10, 6'b100000, 1'b1, 1'b0, 1'b0};
        t[1]  = '{32'h8000_00B7, 5'd1, 64'hFFFF_FFFF_8000_0000, 4'd10, 6'b100000, 1'b1, 1'b0, 1'b0};
        t[2]  = '{32'h0000_1117, 5'd2, 64'h0000_0000_0000_1000, 4'd0,  6'b100000, 1'b1, 1'b1, 1'b0};
        t[3]  = '{32'h4030_D093, 5'd1, 64'd3,                   4'd7,  6'b100000, 1'b1, 1'b0, 1'b0};
        t[4]  = '{32'hFFF0_809B, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0,  6'b100000, 1'b1, 1'b0, 1'b1};
        t[5]  = '{32'h4020_81BB, 5'd3, 64'd0,                   4'd1,  6'b100000, 1'b0, 1'b0, 1'b1};
        t[6]  = '{32'h0080_00EF, 5'd1, 64'd8,                   4'd0,  6'b100010, 1'b1, 1'b1, 1'b0};
        t[7]  = '{32'h0000_8067, 5'd0, 64'd0,                   4'd0,  6'b100001, 1'b1, 1'b0, 1'b0};
        t[8]  = '{32'h0051_2623, 5'd12, 64'd12,                 4'd0,  6'b001000, 1'b1, 1'b0, 1'b0};
        t[9]  = '{32'h0000_0073, 5'd0, 64'd0,                   4'd0,  6'b000000, 1'b0, 1'b0, 1'b0};
        t[10] = '{32'h0FF0_000F, 5'd0, 64'd0,                   4'd0,  6'b000000, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, t[i].ins, 64'h5000 + 64'(i * 4), 1'b0, 1'b0);
            settle();
            vectors++;
            if ({id_valid, id_illegal, id_rd, id_imm, id_alu_op, flags, id_alu_src_imm, id_alu_src_pc, id_is_word}
                !== {1'b1, 1'b0, t[i].rd, t[i].imm, t[i].alu, t[i].fl, t[i].simm, t[i].spc, t[i].word}) begin
                miscompares++;
                $display("FAIL opcode[%0d] %h: got v=%b ill=%b rd=%0d imm=%h alu=%0d fl=%b src=%b%b w=%b exp rd=%0d imm=%h alu=%0d fl=%b src=%b%b w=%b",
                         i, t[i].ins, id_valid, id_illegal, id_rd, id_imm, id_alu_op, flags,
                         id_alu_src_imm, id_alu_src_pc, id_is_word,
                         t[i].rd, t[i].imm, t[i].alu, t[i].fl, t[i].simm, t[i].spc, t[i].word);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad[7];
        bad[0] = 32'h0000_0000;  // all-zero word
        bad[1] = 32'h0000_707F;  // unlisted opcode
        bad[2] = 32'h0000_7003;  // load funct3 111
        bad[3] = 32'h0200_0033;  // OP funct7 0000001
        bad[4] = 32'h4030_9093;  // SLLI with funct6 010000
        bad[5] = 32'h0000_2063;  // branch funct3 010
        bad[6] = 32'h0020_0073;  // SYSTEM other than ECALL/EBREAK
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, bad[i], 64'h6000, 1'b0, 1'b0);
            settle();
            vectors++;
            if ({id_valid, id_illegal, flags} !== {1'b1, 1'b1, 6'b000000}) begin
                miscompares++;
                $display("FAIL illegal[%0d] %h: got v=%b ill=%b flags=%b exp 1/1/000000",
                         i, bad[i], id_valid, id_illegal, flags);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'hFF81_2283, 64'h7000, 1'b0, 1'b0);
        settle();
        @(negedge clk);
        ex_stall = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        vectors++;
        if ({id_valid, fif.fetch_stall, flags, id_rd, id_rs1, id_imm, id_pc, id_funct3, id_alu_src_imm}
            !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b fs=%b flags=%b rd=%0d imm=%h pc=%h f3=%0d exp all 0",
                     id_valid, fif.fetch_stall, flags, id_rd, id_imm, id_pc, id_funct3);
        end
        @(negedge clk);
        resetn   = 1'b1;
        ex_stall = 1'b0;
        fif.instr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_flush();
        test_opcodes();
        test_illegal();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
